// File: rtl/fixed_point_iterative_butterfly_pkg.sv
// Shared types for the iterative fixed-point FFT butterfly.
// Holds the combine-stage FSM encoding used by the butterfly top level.
package fixed_point_iterative_butterfly_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HAVE_A = 2'd1,
        HAVE_P = 2'd2,
        FULL   = 2'd3
    } comb_state_e;

endpackage

// File: rtl/fixed_point_iterative_butterfly_addsub.sv
// Combinational sum/difference of one component pair.
// With scale set, both results are halved with floor rounding and never overflow.
module fixed_point_iterative_butterfly_addsub #(
    parameter int n     = 32,
    parameter int scale = 0
) (
    input  logic [n-1:0] a_i,
    input  logic [n-1:0] b_i,
    output logic [n-1:0] sum_o,
    output logic [n-1:0] dif_o
);

    if (scale != 0) begin : g_scaled
        logic [n:0] a_ext;
        logic [n:0] b_ext;
        logic [n:0] sum_w;
        logic [n:0] dif_w;

        // One guard bit keeps the full result before the halving shift
        assign a_ext = {a_i[n-1], a_i};
        assign b_ext = {b_i[n-1], b_i};
        assign sum_w = a_ext + b_ext;
        assign dif_w = a_ext - b_ext;
        assign sum_o = sum_w[n:1];
        assign dif_o = dif_w[n:1];
    end else begin : g_wrap
        assign sum_o = a_i + b_i;
        assign dif_o = a_i - b_i;
    end

endmodule

// File: rtl/fixed_point_iterative_butterfly_combine.sv
// Joins operand a and product p streams and emits x = a + p, y = a - p.
// Either operand may arrive first; a result is sent before new operands are taken.
module fixed_point_iterative_butterfly_combine
    import fixed_point_iterative_butterfly_pkg::*;
#(
    parameter int n     = 32,
    parameter int d     = 16,
    parameter int scale = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_recv_val,
    output logic         a_recv_rdy,
    input  logic [n-1:0] ar,
    input  logic [n-1:0] ac,
    input  logic         p_recv_val,
    output logic         p_recv_rdy,
    input  logic [n-1:0] pr,
    input  logic [n-1:0] pc,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] xr,
    output logic [n-1:0] xc,
    output logic [n-1:0] yr,
    output logic [n-1:0] yc
);

    if (d < 0 || d >= n) begin : g_bad_d
        $error("fractional bits d must lie in [0, n-1]");
    end

    comb_state_e state_q;
    comb_state_e state_d;

    logic a_fire;
    logic p_fire;
    logic s_fire;

    logic [n-1:0] a_r_q;
    logic [n-1:0] a_c_q;
    logic [n-1:0] p_r_q;
    logic [n-1:0] p_c_q;
    logic [n-1:0] a_r_d;
    logic [n-1:0] a_c_d;
    logic [n-1:0] p_r_d;
    logic [n-1:0] p_c_d;

    assign a_fire = a_recv_val & a_recv_rdy;
    assign p_fire = p_recv_val & p_recv_rdy;
    assign s_fire = send_val & send_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (a_fire && p_fire) begin
                    state_d = FULL;
                end else if (a_fire) begin
                    state_d = HAVE_A;
                end else if (p_fire) begin
                    state_d = HAVE_P;
                end
            end
            HAVE_A: if (p_fire) state_d = FULL;
            HAVE_P: if (a_fire) state_d = FULL;
            FULL:   if (s_fire) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // FULL refuses new operands, so a send never overlaps an accept
    always_comb begin
        a_recv_rdy = 1'b0;
        p_recv_rdy = 1'b0;
        send_val   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                a_recv_rdy = 1'b1;
                p_recv_rdy = 1'b1;
            end
            HAVE_A: p_recv_rdy = 1'b1;
            HAVE_P: a_recv_rdy = 1'b1;
            FULL:   send_val   = 1'b1;
            default: begin
                a_recv_rdy = 1'b0;
                p_recv_rdy = 1'b0;
                send_val   = 1'b0;
            end
        endcase
    end

    always_comb begin
        a_r_d = a_fire ? ar : a_r_q;
        a_c_d = a_fire ? ac : a_c_q;
        p_r_d = p_fire ? pr : p_r_q;
        p_c_d = p_fire ? pc : p_c_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r_q <= '0;
            a_c_q <= '0;
            p_r_q <= '0;
            p_c_q <= '0;
        end else begin
            a_r_q <= a_r_d;
            a_c_q <= a_c_d;
            p_r_q <= p_r_d;
            p_c_q <= p_c_d;
        end
    end

    fixed_point_iterative_butterfly_addsub #(
        .n     (n),
        .scale (scale)
    ) u_re (
        .a_i   (a_r_q),
        .b_i   (p_r_q),
        .sum_o (xr),
        .dif_o (yr)
    );

    fixed_point_iterative_butterfly_addsub #(
        .n     (n),
        .scale (scale)
    ) u_im (
        .a_i   (a_c_q),
        .b_i   (p_c_q),
        .sum_o (xc),
        .dif_o (yc)
    );

endmodule

// File: tb/tb_fixed_point_iterative_butterfly_combine.sv
// Directed and randomized checks of the butterfly combine stage.
// Two instances share stimulus: u_dut0 unscaled, u_dut1 scaled.
module tb_fixed_point_iterative_butterfly_combine;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_recv_val;
    logic        p_recv_val;
    logic        send_rdy;
    logic [31:0] ar, ac, pr, pc;

    logic        a_rdy0, p_rdy0, sval0;
    logic        a_rdy1, p_rdy1, sval1;
    logic [31:0] xr0, xc0, yr0, yc0;
    logic [31:0] xr1, xc1, yr1, yc1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fixed_point_iterative_butterfly_combine #(.n(32), .d(16), .scale(0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .a_recv_val (a_recv_val),
        .a_recv_rdy (a_rdy0),
        .ar         (ar),
        .ac         (ac),
        .p_recv_val (p_recv_val),
        .p_recv_rdy (p_rdy0),
        .pr         (pr),
        .pc         (pc),
        .send_val   (sval0),
        .send_rdy   (send_rdy),
        .xr         (xr0),
        .xc         (xc0),
        .yr         (yr0),
        .yc         (yc0)
    );

    fixed_point_iterative_butterfly_combine #(.n(32), .d(16), .scale(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .a_recv_val (a_recv_val),
        .a_recv_rdy (a_rdy1),
        .ar         (ar),
        .ac         (ac),
        .p_recv_val (p_recv_val),
        .p_recv_rdy (p_rdy1),
        .pr         (pr),
        .pc         (pc),
        .send_val   (sval1),
        .send_rdy   (send_rdy),
        .xr         (xr1),
        .xc         (xc1),
        .yr         (yr1),
        .yc         (yc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag,
                           input logic [31:0] x0r, x0c, y0r, y0c,
                           input logic [31:0] x1r, x1c, y1r, y1c);
        chk({tag, "_xr0"}, xr0, x0r);
        chk({tag, "_xc0"}, xc0, x0c);
        chk({tag, "_yr0"}, yr0, y0r);
        chk({tag, "_yc0"}, yc0, y0c);
        chk({tag, "_xr1"}, xr1, x1r);
        chk({tag, "_xc1"}, xc1, x1c);
        chk({tag, "_yr1"}, yr1, y1r);
        chk({tag, "_yc1"}, yc1, y1c);
    endtask

    task automatic chk_ctl(input string tag, input logic sv, input logic ardy, input logic prdy);
        chk({tag, "_sval0"}, 32'(sval0), 32'(sv));
        chk({tag, "_sval1"}, 32'(sval1), 32'(sv));
        chk({tag, "_ardy"},  32'(a_rdy0), 32'(ardy));
        chk({tag, "_prdy"},  32'(p_rdy0), 32'(prdy));
        chk({tag, "_ardy1"}, 32'(a_rdy1), 32'(ardy));
        chk({tag, "_prdy1"}, 32'(p_rdy1), 32'(prdy));
    endtask

    // Called at a negedge; presents the selected operands for one cycle
    task automatic put(input bit do_a, input bit do_p,
                       input logic [31:0] a_r, a_c, p_r, p_c);
        ar = a_r; ac = a_c; pr = p_r; pc = p_c;
        a_recv_val = do_a;
        p_recv_val = do_p;
        @(negedge clk);
        a_recv_val = 1'b0;
        p_recv_val = 1'b0;
        ar = 32'hDEAD_BEEF; ac = 32'hDEAD_BEEF;
        pr = 32'hDEAD_BEEF; pc = 32'hDEAD_BEEF;
    endtask

    task automatic drain(input string tag);
        send_rdy = 1'b1;
        @(negedge clk);
        send_rdy = 1'b0;
        chk_ctl(tag, 1'b0, 1'b1, 1'b1);
    endtask

    function automatic logic [31:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                         input bit sub, input bit scl);
        longint s;
        s = longint'($signed(a));
        if (sub) s = s - longint'($signed(b));
        else     s = s + longint'($signed(b));
        if (scl) s = s >>> 1;
        return s[31:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] qa_r[$], qa_c[$], qp_r[$], qp_c[$];
        logic [31:0] ea_r, ea_c, ep_r, ep_c;
        int na, np, ns, cyc;

        reset = 1'b0;
        a_recv_val = 1'b0; p_recv_val = 1'b0; send_rdy = 1'b0;
        ar = '0; ac = '0; pr = '0; pc = '0;
        #1;
        chk_ctl("rst", 1'b0, 1'b1, 1'b1);
        chk_out("rst", 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        put(1, 1, 32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'hFFFF_C000);
        chk_ctl("sim", 1'b1, 1'b0, 1'b0);
        chk_out("sim", 32'h0001_4000, 32'h0000_4000, 32'h0000_C000, 32'h0000_C000,
                       32'h0000_A000, 32'h0000_2000, 32'h0000_6000, 32'h0000_6000);
        drain("sim_drain");

        // a first, p held off for 5 cycles
        put(1, 0, 32'h3, 32'h5, 32'h1234, 32'h5678);
        for (int i = 0; i < 5; i++) begin
            chk_ctl("wait_p", 1'b0, 1'b0, 1'b1);
            @(negedge clk);
        end
        put(0, 1, 32'hAAAA_AAAA, 32'h5555_5555, 32'h1, 32'h2);
        chk_ctl("a1st", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_out("a1st_hold", 32'h4, 32'h7, 32'h2, 32'h3, 32'h2, 32'h3, 32'h1, 32'h1);
            chk_ctl("a1st_hold", 1'b1, 1'b0, 1'b0);
            @(negedge clk);
        end
        drain("a1st_drain");

        // p first
        put(0, 1, 32'h0, 32'h0, 32'h8, 32'h20);
        for (int i = 0; i < 5; i++) begin
            chk_ctl("wait_a", 1'b0, 1'b1, 1'b0);
            @(negedge clk);
        end
        put(1, 0, 32'hFFFF_FFF0, 32'h100, 32'h7777_7777, 32'h7777_7777);
        chk_ctl("p1st", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_out("p1st_hold", 32'hFFFF_FFF8, 32'h120, 32'hFFFF_FFE8, 32'hE0,
                                 32'hFFFF_FFFC, 32'h90, 32'hFFFF_FFF4, 32'h70);
            @(negedge clk);
        end
        drain("p1st_drain");

        put(1, 1, 32'h7FFF_FFFF, 32'h0, 32'h1, 32'h0);
        chk_out("ovf", 32'h8000_0000, 32'h0, 32'h7FFF_FFFE, 32'h0,
                       32'h4000_0000, 32'h0, 32'h3FFF_FFFF, 32'h0);
        drain("ovf_drain");

        put(1, 1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
        chk_out("floor", 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0,
                         32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0);
        drain("floor_drain");

        // async reset while holding a
        put(1, 0, 32'h100, 32'h200, 32'h0, 32'h0);
        #2 reset = 1'b0;
        #1;
        chk_ctl("rst_ha", 1'b0, 1'b1, 1'b1);
        chk_out("rst_ha", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        put(0, 1, 32'h0, 32'h0, 32'h1, 32'h1);
        chk_ctl("rst_ha_p", 1'b0, 1'b1, 1'b0);
        put(1, 0, 32'h5, 32'h6, 32'h0, 32'h0);
        chk_out("post_ha", 32'h6, 32'h7, 32'h4, 32'h5, 32'h3, 32'h3, 32'h2, 32'h2);
        drain("post_ha_drain");

        // async reset with a pending result
        put(1, 1, 32'h10, 32'h10, 32'h20, 32'h20);
        chk_ctl("full", 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk_ctl("rst_full", 1'b0, 1'b1, 1'b1);
        chk_out("rst_full", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        put(1, 1, 32'h9, 32'hFFFF_FFFD, 32'h3, 32'h2);
        chk_out("post_full", 32'hC, 32'hFFFF_FFFF, 32'h6, 32'hFFFF_FFFB,
                             32'h6, 32'hFFFF_FFFF, 32'h3, 32'hFFFF_FFFD);
        drain("post_full_drain");

        // random streaming against an in-order model
        na = 0; np = 0; ns = 0; cyc = 0;
        while (ns < 1000 && cyc < 20000) begin
            cyc++;
            a_recv_val = (na < 1000) && ($urandom_range(0, 1) == 1);
            p_recv_val = (np < 1000) && ($urandom_range(0, 1) == 1);
            send_rdy   = ($urandom_range(0, 1) == 1);
            ar = $urandom; ac = $urandom; pr = $urandom; pc = $urandom;
            #1;
            if (a_recv_val && a_rdy0) begin
                qa_r.push_back(ar); qa_c.push_back(ac); na++;
            end
            if (p_recv_val && p_rdy0) begin
                qp_r.push_back(pr); qp_c.push_back(pc); np++;
            end
            if (sval0 && send_rdy) begin
                if (qa_r.size() > 1 || qp_r.size() > 1 ||
                    (a_recv_val && a_rdy0) || (p_recv_val && p_rdy0)) begin
                    chk("stream_overlap", 32'd1, 32'd0);
                end
                if (qa_r.size() == 0 || qp_r.size() == 0) begin
                    chk("stream_extra", 32'd1, 32'd0);
                end else begin
                    ea_r = qa_r.pop_front(); ea_c = qa_c.pop_front();
                    ep_r = qp_r.pop_front(); ep_c = qp_c.pop_front();
                    chk("s_xr0", xr0, bfly(ea_r, ep_r, 0, 0));
                    chk("s_xc0", xc0, bfly(ea_c, ep_c, 0, 0));
                    chk("s_yr0", yr0, bfly(ea_r, ep_r, 1, 0));
                    chk("s_yc0", yc0, bfly(ea_c, ep_c, 1, 0));
                    chk("s_xr1", xr1, bfly(ea_r, ep_r, 0, 1));
                    chk("s_xc1", xc1, bfly(ea_c, ep_c, 0, 1));
                    chk("s_yr1", yr1, bfly(ea_r, ep_r, 1, 1));
                    chk("s_yc1", yc1, bfly(ea_c, ep_c, 1, 1));
                    chk("s_sval1", 32'(sval1), 32'd1);
                end
                ns++;
            end
            @(negedge clk);
        end
        a_recv_val = 1'b0; p_recv_val = 1'b0; send_rdy = 1'b0;
        chk("stream_sent", 32'(ns), 32'd1000);
        chk("stream_a_left", 32'(qa_r.size()), 32'd0);
        chk("stream_p_left", 32'(qp_r.size()), 32'd0);
        #1;
        chk_ctl("stream_end", 1'b0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
